// File: rtl/delta_encoder.sv
// rtl/delta_encoder.sv - absolute-sample to load/step beat encoder for a far-end delta_counter
module delta_encoder #(
    parameter int WIDTH     = 8,
    parameter int MAX_DELTA = 2**WIDTH - 1,
    parameter bit SKIP_ZERO = 1'b1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clear_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] in_value_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic             out_load_o,
    output logic             out_down_o,
    output logic [WIDTH-1:0] out_data_o,
    output logic             synced_o
);

    localparam logic [1:0] S_UNSYNC = 2'd0;
    localparam logic [1:0] S_IDLE   = 2'd1;
    localparam logic [1:0] S_LOAD   = 2'd2;
    localparam logic [1:0] S_STEP   = 2'd3;

    localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX_DELTA);
    localparam logic [WIDTH-1:0] HALF  = {1'b1, {(WIDTH-1){1'b0}}};

    logic [1:0]       state_q;
    logic [WIDTH-1:0] ref_q;
    logic [WIDTH-1:0] rem_q;
    logic             out_valid_q;
    logic             out_load_q;
    logic             out_down_q;
    logic [WIDTH-1:0] out_data_q;
    logic             synced_q;

    logic             accept;
    logic             handshake;
    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] mag;
    logic             dir_down;
    logic [WIDTH-1:0] rem_next;

    // Largest chunk a single step beat may carry.
    function automatic logic [WIDTH-1:0] clip(input logic [WIDTH-1:0] v);
        clip = (v > MAX_W) ? MAX_W : v;
    endfunction

    // Ready depends only on state; clear blocks acceptance in the same cycle.
    assign in_ready_o = ((state_q == S_UNSYNC) || (state_q == S_IDLE)) && !clear_i;
    assign accept     = in_valid_i && in_ready_o;
    assign handshake  = out_valid_q && out_ready_i;

    assign out_valid_o = out_valid_q;
    assign out_load_o  = out_load_q;
    assign out_down_o  = out_down_q;
    assign out_data_o  = out_data_q;
    assign synced_o    = synced_q;

    // Shortest modular direction; the exact half-range tie goes up.
    always_comb begin
        diff     = in_value_i - ref_q;
        dir_down = 1'b0;
        mag      = diff;
        if (diff > HALF) begin
            dir_down = 1'b1;
            mag      = {WIDTH{1'b0}} - diff;
        end
        rem_next = rem_q - out_data_q;
    end

    // Beat sequencing: load on first sample, chunked steps afterwards.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= S_UNSYNC;
            ref_q       <= '0;
            rem_q       <= '0;
            out_valid_q <= 1'b0;
            out_load_q  <= 1'b0;
            out_down_q  <= 1'b0;
            out_data_q  <= '0;
            synced_q    <= 1'b0;
        end else if (clear_i) begin
            state_q     <= S_UNSYNC;
            ref_q       <= '0;
            rem_q       <= '0;
            out_valid_q <= 1'b0;
            out_load_q  <= 1'b0;
            out_down_q  <= 1'b0;
            out_data_q  <= '0;
            synced_q    <= 1'b0;
        end else begin
            case (state_q)
                S_UNSYNC: begin
                    if (accept) begin
                        state_q     <= S_LOAD;
                        ref_q       <= in_value_i;
                        out_valid_q <= 1'b1;
                        out_load_q  <= 1'b1;
                        out_down_q  <= 1'b0;
                        out_data_q  <= in_value_i;
                        synced_q    <= 1'b1;
                    end
                end
                S_IDLE: begin
                    if (accept) begin
                        ref_q <= in_value_i;
                        // A zero magnitude still yields one zero step when not skipped.
                        if ((mag != '0) || !SKIP_ZERO) begin
                            state_q     <= S_STEP;
                            rem_q       <= mag;
                            out_valid_q <= 1'b1;
                            out_load_q  <= 1'b0;
                            out_down_q  <= dir_down;
                            out_data_q  <= clip(mag);
                        end
                    end
                end
                S_LOAD: begin
                    if (handshake) begin
                        state_q     <= S_IDLE;
                        out_valid_q <= 1'b0;
                        out_load_q  <= 1'b0;
                        out_data_q  <= '0;
                    end
                end
                S_STEP: begin
                    if (handshake) begin
                        rem_q <= rem_next;
                        if (rem_next == '0) begin
                            state_q     <= S_IDLE;
                            out_valid_q <= 1'b0;
                            out_down_q  <= 1'b0;
                            out_data_q  <= '0;
                        end else begin
                            out_data_q <= clip(rem_next);
                        end
                    end
                end
                default: begin
                    state_q     <= S_UNSYNC;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_delta_encoder.sv
// tb/tb_delta_encoder.sv - directed self-checking bench for delta_encoder
module tb_delta_encoder;

    logic       clk = 1'b0;
    logic       rst_n;

    logic       a_clear, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic       a_out_load, a_out_down, a_synced;
    logic [7:0] a_in_value, a_out_data;

    logic       b_clear, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic       b_out_load, b_out_down, b_synced;
    logic [7:0] b_in_value, b_out_data;

    logic [7:0] a_q, b_q;
    int         n_chk  = 0;
    int         n_pass = 0;

    delta_encoder #(.WIDTH(8), .MAX_DELTA(100), .SKIP_ZERO(1'b1)) dut_a (
        .clk_i(clk), .rst_ni(rst_n), .clear_i(a_clear),
        .in_valid_i(a_in_valid), .in_ready_o(a_in_ready), .in_value_i(a_in_value),
        .out_valid_o(a_out_valid), .out_ready_i(a_out_ready), .out_load_o(a_out_load),
        .out_down_o(a_out_down), .out_data_o(a_out_data), .synced_o(a_synced)
    );

    delta_encoder #(.WIDTH(8), .MAX_DELTA(1), .SKIP_ZERO(1'b0)) dut_b (
        .clk_i(clk), .rst_ni(rst_n), .clear_i(b_clear),
        .in_valid_i(b_in_valid), .in_ready_o(b_in_ready), .in_value_i(b_in_value),
        .out_valid_o(b_out_valid), .out_ready_i(b_out_ready), .out_load_o(b_out_load),
        .out_down_o(b_out_down), .out_data_o(b_out_data), .synced_o(b_synced)
    );

    always #5 clk = ~clk;

    // Far-end delta_counter models fed by accepted beats.
    always @(posedge clk) begin
        if (a_out_valid && a_out_ready)
            a_q <= a_out_load ? a_out_data : (a_out_down ? a_q - a_out_data : a_q + a_out_data);
        if (b_out_valid && b_out_ready)
            b_q <= b_out_load ? b_out_data : (b_out_down ? b_q - b_out_data : b_q + b_out_data);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic send_a(input logic [7:0] v);
        a_in_valid = 1'b1;
        a_in_value = v;
        tick();
        a_in_valid = 1'b0;
    endtask

    task automatic send_b(input logic [7:0] v);
        b_in_valid = 1'b1;
        b_in_value = v;
        tick();
        b_in_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        a_clear = 0; a_in_valid = 0; a_in_value = '0; a_out_ready = 1;
        b_clear = 0; b_in_valid = 0; b_in_value = '0; b_out_ready = 1;
        tick(); tick();
        chk("rst_in_ready", a_in_ready, 1);
        chk("rst_out_valid", a_out_valid, 0);
        chk("rst_out_load", a_out_load, 0);
        chk("rst_out_down", a_out_down, 0);
        chk("rst_out_data", a_out_data, 0);
        chk("rst_synced", a_synced, 0);
        rst_n = 1'b1;
        tick();

        // First sample and small step
        send_a(8'h20);
        chk("t1_load_valid", a_out_valid, 1);
        chk("t1_load_flag", a_out_load, 1);
        chk("t1_load_data", a_out_data, 8'h20);
        chk("t1_synced", a_synced, 1);
        chk("t1_busy", a_in_ready, 0);
        tick();
        chk("t1_idle_ready", a_in_ready, 1);
        chk("t1_idle_valid", a_out_valid, 0);
        send_a(8'h25);
        chk("t1_step_valid", a_out_valid, 1);
        chk("t1_step_load", a_out_load, 0);
        chk("t1_step_down", a_out_down, 0);
        chk("t1_step_data", a_out_data, 5);
        tick();
        chk("t1_model", a_q, 8'h25);

        // Wrap-around downward
        send_a(8'h10);
        tick();
        chk("t2_ref_model", a_q, 8'h10);
        send_a(8'hF0);
        chk("t2_down", a_out_down, 1);
        chk("t2_data", a_out_data, 32);
        tick();
        chk("t2_model", a_q, 8'hF0);
        chk("t2_idle_valid", a_out_valid, 0);

        // Tie plus chunking
        send_a(8'h00);
        tick();
        send_a(8'h80);
        chk("t3_c1_ready", a_in_ready, 0);
        chk("t3_c1_down", a_out_down, 0);
        chk("t3_c1_data", a_out_data, 100);
        tick();
        chk("t3_c2_ready", a_in_ready, 0);
        chk("t3_c2_data", a_out_data, 28);
        tick();
        chk("t3_ready_back", a_in_ready, 1);
        chk("t3_valid_off", a_out_valid, 0);
        chk("t3_model", a_q, 8'h80);

        // Backpressure
        send_a(8'h00);
        tick(); tick();
        chk("t4_pre_model", a_q, 8'h00);
        a_out_ready = 1'b0;
        send_a(8'hC8);
        for (int i = 0; i < 3; i++) begin
            chk("t4_stall_valid", a_out_valid, 1);
            chk("t4_stall_down", a_out_down, 1);
            chk("t4_stall_data", a_out_data, 56);
            chk("t4_stall_ready", a_in_ready, 0);
            tick();
        end
        a_out_ready = 1'b1;
        chk("t4_c4_valid", a_out_valid, 1);
        chk("t4_c4_data", a_out_data, 56);
        tick();
        chk("t4_done_valid", a_out_valid, 0);
        chk("t4_done_ready", a_in_ready, 1);
        chk("t4_model", a_q, 8'hC8);

        // Clear between chunks, then zero delta
        send_a(8'h00);
        tick();
        send_a(8'h80);
        chk("t5_c1_data", a_out_data, 100);
        a_clear = 1'b1;
        tick();
        chk("t5_clr_valid", a_out_valid, 0);
        chk("t5_clr_synced", a_synced, 0);
        a_in_valid = 1'b1;
        a_in_value = 8'h77;
        #1;
        chk("t5_clr_gates_ready", a_in_ready, 0);
        tick();
        a_clear = 1'b0;
        a_in_valid = 1'b0;
        chk("t5_no_accept_valid", a_out_valid, 0);
        chk("t5_no_accept_synced", a_synced, 0);
        send_a(8'h33);
        chk("t5_load_flag", a_out_load, 1);
        chk("t5_load_data", a_out_data, 8'h33);
        tick();
        send_a(8'h33);
        chk("t5_zero_valid", a_out_valid, 0);
        chk("t5_zero_ready", a_in_ready, 1);
        tick();
        chk("t5_zero_valid2", a_out_valid, 0);
        chk("t5_model", a_q, 8'h33);

        // Reset mid-beat, then next sample loads
        send_a(8'h40);
        chk("t6_step_valid", a_out_valid, 1);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_valid", a_out_valid, 0);
        chk("t6_rst_synced", a_synced, 0);
        tick();
        rst_n = 1'b1;
        tick();
        send_a(8'h41);
        chk("t6_load_flag", a_out_load, 1);
        chk("t6_load_data", a_out_data, 8'h41);
        tick();

        // MAX_DELTA=1, SKIP_ZERO=0
        send_b(8'd5);
        chk("t7_load_flag", b_out_load, 1);
        chk("t7_load_data", b_out_data, 5);
        tick();
        send_b(8'd8);
        for (int i = 0; i < 3; i++) begin
            chk("t7_beat_valid", b_out_valid, 1);
            chk("t7_beat_down", b_out_down, 0);
            chk("t7_beat_data", b_out_data, 1);
            chk("t7_beat_ready", b_in_ready, 0);
            tick();
        end
        chk("t7_done_valid", b_out_valid, 0);
        chk("t7_model", b_q, 8'd8);
        send_b(8'd8);
        chk("t7_zero_valid", b_out_valid, 1);
        chk("t7_zero_load", b_out_load, 0);
        chk("t7_zero_down", b_out_down, 0);
        chk("t7_zero_data", b_out_data, 0);
        tick();
        chk("t7_zero_done", b_out_valid, 0);
        chk("t7_zero_ready", b_in_ready, 1);
        chk("t7_zero_model", b_q, 8'd8);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/delta_encoder.md
# delta_encoder

Converts a stream of absolute WIDTH-bit sample values into the beat stream that a `delta_counter` at the far end consumes. The far end reproduces every sample in its `q_o` by applying each beat in one of two ways. A load beat drives `load_i`/`d_i`. A step beat drives `en_i`/`down_i`/`delta_i`. Sits on the transmit side of delta-compressed links, for example timestamp or pointer forwarding. It picks the shortest modular direction and splits large deltas into bounded chunks.

## Interface

- `WIDTH`, 8: sample and delta width, ≥ 2.
- `MAX_DELTA`, 2**WIDTH-1: largest magnitude of one step beat, 1..2**WIDTH-1.
- `SKIP_ZERO`, 1'b1: if 1, a zero delta emits no beat.
- `clk_i` in 1: clock.
- `rst_ni` in 1: asynchronous active-low reset.
- `clear_i` in 1: synchronous clear; aborts pending beats and drops the reference.
- `in_valid_i` in 1: sample valid.
- `in_ready_o` out 1: block can accept a sample.
- `in_value_i` in WIDTH: absolute sample.
- `out_valid_o` out 1: beat valid.
- `out_ready_i` in 1: far end accepts the beat.
- `out_load_o` out 1: 1 means load beat (absolute value); 0 means step beat.
- `out_down_o` out 1: step direction, 1 means subtract; 0 on load beats.
- `out_data_o` out WIDTH: load value or step magnitude.
- `synced_o` out 1: a reference value is held.

## Operation

- States:
  - UNSYNC: reset state, no reference held.
  - IDLE: reference held.
  - LOAD: presenting a load beat.
  - STEP: presenting step beats.
- Register `ref_q` (WIDTH bits) holds the last accepted sample. Register `rem_q` (WIDTH bits) holds the remaining step magnitude.
- `in_ready_o` = 1 exactly in UNSYNC and IDLE. A sample is accepted when `in_valid_i & in_ready_o`.
- Accept in UNSYNC:
  - `ref_q` ← sample; go to LOAD.
  - Beat presented: `out_load_o`=1, `out_data_o`=sample.
- Accept in IDLE:
  - `diff` = (sample − `ref_q`) mod 2**WIDTH; `ref_q` ← sample.
  - If `diff` ≤ 2**(WIDTH-1): direction up, magnitude `diff`. The tie at exactly 2**(WIDTH-1) goes up.
  - Otherwise: direction down, magnitude 2**WIDTH − `diff`.
  - Magnitude 0 with SKIP_ZERO=1: stay in IDLE, emit nothing.
  - Magnitude 0 with SKIP_ZERO=0: one step beat, data 0, down 0.
  - Otherwise: go to STEP, `rem_q` ← magnitude.
- STEP beat content: `out_data_o` = min(`rem_q`, MAX_DELTA), `out_down_o` = direction, `out_load_o` = 0.
- STEP handshake:
  - On a handshake, `rem_q` ← `rem_q` − `out_data_o`.
  - When the result is 0, go to IDLE.
  - Chunk count = ceil(magnitude / MAX_DELTA). All chunks are MAX_DELTA except a smaller final one.
- LOAD handshake: go to IDLE.
- Output stability: while `out_valid_o` & !`out_ready_i`, all `out_*` outputs hold their values.
- `clear_i`:
  - Highest priority. Next state is UNSYNC, `out_valid_o`=0, `rem_q`=0, `synced_o`=0.
  - A sample presented in the same cycle is not accepted, because `in_ready_o` is forced 0 while `clear_i` is 1.
- `synced_o` = 1 in every state except UNSYNC. It rises on the LOAD-state entry edge.
- Reset mid-beat: all state is lost, the block returns to UNSYNC, and the next sample emits a load beat.
- Invariant: applying every accepted beat in order to a WIDTH-bit delta_counter (load beat → `load_i`; step beat → `en_i`) leaves `q_o` equal to the last accepted sample.

## Timing

- Reset values:
  - `in_ready_o`=1
  - `out_valid_o`=0
  - `out_load_o`=0
  - `out_down_o`=0
  - `out_data_o`=0
  - `synced_o`=0
  - state UNSYNC, `ref_q`=0
- All `out_*` outputs and `synced_o` are registered. `in_ready_o` is decoded from state only, apart from the `clear_i` gating.
- Latency: a sample accepted at edge t has its first beat valid after edge t, i.e. in cycle t+1.
- With `out_ready_i`=1 continuously:
  - One beat per cycle.
  - A single-beat sample occupies 2 cycles: `in_ready_o` returns high the cycle after the last beat's handshake.
  - Throughput is 1 sample per 2 cycles; an n-chunk sample takes n+1 cycles.
- No combinational path from `out_ready_i` or `in_valid_i` to any output.

## Test plan

Unless stated, WIDTH=8, MAX_DELTA=100, SKIP_ZERO=1, `out_ready_i`=1.

- **First sample and small step.** Reset, then samples 0x20 and 0x25 → beat load/0x20 in cycle 1; `synced_o`=1; second sample gives one beat step up, data 5.
- **Wrap-around downward.** Reference 0x10, sample 0xF0 (diff 224) → one step beat, down=1, data 32. Check a model delta_counter reads 0xF0.
- **Tie plus chunking.** Reference 0x00, sample 0x80 → step beats up 100 then up 28. `in_ready_o` is low for 2 cycles and returns to 1 in the 3rd.
- **Backpressure.** Hold `out_ready_i`=0 for 3 cycles during the first chunk of a 0x00→0xC8 sample (down, 56 ≤ MAX_DELTA, single beat) → `out_valid_o`, `out_down_o`=1 and `out_data_o`=56 stay stable, and `in_ready_o` stays 0. The handshake then completes in the 4th cycle.
- **Clear and zero delta.**
  - `clear_i` pulsed between the two chunks of 0x00→0x80 → `out_valid_o`=0 and `synced_o`=0 next cycle; the next sample 0x33 emits load/0x33.
  - Then repeat sample 0x33 → no beat, `in_ready_o` stays 1.
- **SKIP_ZERO=0 and MAX_DELTA=1.** With MAX_DELTA=1, reference 5 and sample 8 → three step beats up, data 1 each. With SKIP_ZERO=0, a repeated sample emits one beat up, data 0.
